serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the 1-bit half adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a registered carry chain.
- Valid/ready handshakes on both input and output.
- Used where area matters more than throughput, e.g. accumulator and counter datapaths; trades latency for a single DIGIT-bit adder slice.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly, otherwise elaboration fails ($fatal).
- NSTEPS = WIDTH/DIGIT is derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in, add mode only
- op_sub  input  1  0: a+b+cin; 1: a-b (cin ignored)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out; in subtract mode 1 = no borrow
- ovf  output  1  signed (two's complement) overflow

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. On any edge with rst_n=0: state IDLE, sum=0, cout=0, ovf=0, out_valid=0, internal shift registers/counter/carry cleared.
- in_ready = (state==IDLE), combinational. It is 1 in the cycle after the reset edge.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge with in_valid && in_ready.
  - Capture a into a shift register.
  - Capture (op_sub ? ~b : b) into a second shift register.
  - Set carry register to (op_sub ? 1 : cin).
  - Clear step counter to 0.
- RUN: each edge processes one digit.
  - Add the low DIGIT bits of both shift registers plus carry.
  - Shift the DIGIT-bit result into sum from the MSB side; shift both operand registers right by DIGIT.
  - Update carry with the slice carry-out; increment the counter.
  - On the edge processing step NSTEPS-1: go to DONE, register cout = final carry.
  - Register ovf = carry into MSB XOR carry out of MSB.
- Latency: out_valid rises in the cycle exactly NSTEPS clocks after the accepting edge (WIDTH=8, DIGIT=1 -> 8 cycles).
- DONE: out_valid=1. sum, cout and ovf are held stable until an edge with out_valid && out_ready; that edge -> IDLE, out_valid=0.
- No new input is accepted in the same cycle as output drain, since in_ready=0 in DONE.
- Throughput: one operation per NSTEPS+2 cycles minimum.
- a, b, cin, op_sub are sampled only on the accepting edge. Changes during RUN/DONE have no effect.
- in_valid during RUN/DONE is ignored; it is not queued.
- sum during RUN holds partial/shifting contents and is valid only when out_valid=1.
- Reset mid-RUN or mid-DONE: the operation is discarded, out_valid=0, and no result is ever presented.
- Wrap-around: sum is modulo 2^WIDTH. The carry beyond the MSB appears only on cout.

Test Plan:
1. Reset (WIDTH=8, DIGIT=1): hold rst_n=0 two cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 the cycle after rst_n=1; no operation was accepted during reset.
2. Add a=0x5A, b=0x3C, cin=0 -> exactly 8 cycles after accept: out_valid=1, sum=0x96, cout=0, ovf=1. Then a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
3. Subtract op_sub=1:
   - a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0.
   - a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
   - cin=1 applied in both cases has no effect.
4. Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and a/b toggling -> sum/cout/ovf stable, in_ready=0. Raise out_ready -> out_valid=0 next cycle, in_ready=1, and the next operation is accepted only then.
5. Reset mid-operation: assert rst_n=0 for one edge at RUN step 4 -> out_valid never asserts for that operation. in_ready=1 the cycle after release; a following 0x01+0x01 yields 0x02.
6. Parameter sweep:
   - WIDTH=8, DIGIT=4: 0xF0+0x10 -> sum=0x00, cout=1, out_valid 2 cycles after accept.
   - WIDTH=16, DIGIT=2: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, latency 8.
   - WIDTH=6, DIGIT=4 -> elaboration error.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: adds two WIDTH-bit operands DIGIT bits per clock
// through one registered-carry adder slice, with valid/ready on both sides.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SAFE_DIGIT = (DIGIT > 0) ? DIGIT : 1;
    localparam int NSTEPS     = WIDTH / SAFE_DIGIT;
    localparam int CW         = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % SAFE_DIGIT) != 0) begin : g_bad_params
        $fatal(1, "serial_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic [DIGIT-1:0]  slice_a;
    logic [DIGIT-1:0]  slice_b;
    logic [DIGIT-1:0]  slice_s;
    logic              slice_c;
    logic              msb_carry;
    logic              last_step;
    logic [WIDTH-1:0]  sum_shift;

    assign slice_a = a_sh[DIGIT-1:0];
    assign slice_b = b_sh[DIGIT-1:0];
    assign {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, carry};
    // Carry into the top bit of the slice, recovered from its sum bit; only meaningful on the last step.
    assign msb_carry = slice_a[DIGIT-1] ^ slice_b[DIGIT-1] ^ slice_s[DIGIT-1];
    assign last_step = (cnt == LAST);

    if (DIGIT < WIDTH) begin : g_shift
        assign sum_shift = {slice_s, sum[WIDTH-1:DIGIT]};
    end else begin : g_whole
        assign sum_shift = slice_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, so the operand is inverted and the carry preset on capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= op_sub ? ~b : b;
                        carry <= op_sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    sum   <= sum_shift;
                    carry <= slice_c;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        cout <= slice_c;
                        ovf  <= msb_carry ^ slice_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: 8/1 main instance plus 8/4 and 16/2 variants.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout, ovf;
    logic [7:0]  a, b, sum;

    logic        d4_in_valid, d4_in_ready, d4_cin, d4_op_sub, d4_out_valid, d4_out_ready, d4_cout, d4_ovf;
    logic [7:0]  d4_a, d4_b, d4_sum;

    logic        w16_in_valid, w16_in_ready, w16_cin, w16_op_sub, w16_out_valid, w16_out_ready, w16_cout, w16_ovf;
    logic [15:0] w16_a, w16_b, w16_sum;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .b(d4_b), .cin(d4_cin), .op_sub(d4_op_sub), .out_valid(d4_out_valid),
        .out_ready(d4_out_ready), .sum(d4_sum), .cout(d4_cout), .ovf(d4_ovf)
    );

    serial_adder #(.WIDTH(16), .DIGIT(2)) dut_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
        .a(w16_a), .b(w16_b), .cin(w16_cin), .op_sub(w16_op_sub), .out_valid(w16_out_valid),
        .out_ready(w16_out_ready), .sum(w16_sum), .cout(w16_cout), .ovf(w16_ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 8/1 instance; operands are scrambled after the accepting edge.
    task automatic applyStimulus(input string tag, input logic [7:0] va, input logic [7:0] vb,
                                 input logic vcin, input logic vsub,
                                 input logic [7:0] esum, input logic ecout, input logic eovf);
        int lat;
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = va; b = vb; cin = vcin; op_sub = vsub; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a = ~va; b = ~vb; cin = ~vcin; op_sub = ~vsub;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd8);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(esum));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(ecout));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;

        rst_n = 1'b0;
        in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; op_sub = 1'b0; out_ready = 1'b0;
        d4_in_valid = 1'b0; d4_a = '0; d4_b = '0; d4_cin = 1'b0; d4_op_sub = 1'b0; d4_out_ready = 1'b0;
        w16_in_valid = 1'b0; w16_a = '0; w16_b = '0; w16_cin = 1'b0; w16_op_sub = 1'b0; w16_out_ready = 1'b0;

        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_no_accept", 32'(out_valid), 32'd0);

        applyStimulus("add1", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        applyStimulus("add2", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        applyStimulus("sub1", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        applyStimulus("sub2", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure with in_valid held high and operands toggling throughout.
        a = 8'h12; b = 8'h34; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        tick();
        lat = 0;
        while (!out_valid && lat < 20) begin
            a = a ^ 8'hFF; b = b ^ 8'h0F;
            tick();
            lat++;
        end
        checkOutput("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            a = 8'(i * 37); b = 8'(i * 11 + 3);
            tick();
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_sum", 32'(sum), 32'h46);
            checkOutput("bp_hold_cout", 32'(cout), 32'd0);
            checkOutput("bp_hold_ovf", 32'(ovf), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        a = 8'h22; b = 8'h11;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_drain_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_drain_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_next_accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("bp_next_latency", 32'(lat), 32'd8);
        checkOutput("bp_next_sum", 32'(sum), 32'h33);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset lands on the edge that would process step 4.
        a = 8'h40; b = 8'h40; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checkOutput("midrst_no_result", 32'(seen), 32'd0);
        applyStimulus("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        d4_a = 8'hF0; d4_b = 8'h10; d4_in_valid = 1'b1;
        tick();
        d4_in_valid = 1'b0;
        lat = 0;
        while (!d4_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("d4_latency", 32'(lat), 32'd2);
        checkOutput("d4_sum", 32'(d4_sum), 32'h00);
        checkOutput("d4_cout", 32'(d4_cout), 32'd1);
        checkOutput("d4_ovf", 32'(d4_ovf), 32'd0);
        d4_out_ready = 1'b1;
        tick();
        d4_out_ready = 1'b0;
        checkOutput("d4_drained", 32'(d4_out_valid), 32'd0);

        w16_a = 16'h7FFF; w16_b = 16'h0001; w16_in_valid = 1'b1;
        tick();
        w16_in_valid = 1'b0;
        lat = 0;
        while (!w16_out_valid && lat < 30) begin
            tick();
            lat++;
        end
        checkOutput("w16_latency", 32'(lat), 32'd8);
        checkOutput("w16_sum", 32'(w16_sum), 32'h8000);
        checkOutput("w16_cout", 32'(w16_cout), 32'd0);
        checkOutput("w16_ovf", 32'(w16_ovf), 32'd1);
        w16_out_ready = 1'b1;
        tick();
        w16_out_ready = 1'b0;
        checkOutput("w16_drained", 32'(w16_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
